// File: rtl/wr_rd_scoreboard_mon.sv
// Bindable wr/rd data-path checker: reference queue model, latency-aligned read
// compare, full/empty flag checks, sticky first-error capture and coverage counters.
module wr_rd_scoreboard_mon #(
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [DW-1:0]            in,
  input  logic [DW-1:0]            out,
  input  logic                     dut_full,
  input  logic                     dut_empty,
  output logic                     err,
  output logic [2:0]               err_code,
  output logic [DW-1:0]            exp_data,
  output logic [DW-1:0]            obs_data,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         wr_cnt,
  output logic [CNT_W-1:0]         rd_cnt,
  output logic [CNT_W-1:0]         cov_full,
  output logic [CNT_W-1:0]         cov_simul
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic [DW-1:0]    exp_q, exp_d, obs_q, obs_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] cov_full_q, cov_full_d, cov_simul_q, cov_simul_d;

  logic          wr_x, rd_x, wr_ok, rd_ok, wr_acc, rd_acc;
  logic          ev_ovf, ev_udf, ev_dat, ev_full, ev_emp, any_ev;
  logic [2:0]    ev_num, ev_code;
  logic [1:0]    ev_inc;
  logic          cmp_vld;
  logic [DW-1:0] cmp_dat, head;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Unknown strobes are errors and are masked so X never reaches the model state.
  assign wr_x   = $isunknown(wr);
  assign rd_x   = $isunknown(rd);
  assign wr_ok  = wr & ~wr_x;
  assign rd_ok  = rd & ~rd_x;
  assign rd_acc = rd_ok & (level_q != '0);
  assign wr_acc = wr_ok & ((level_q < LVL_FULL) | rd_acc);
  assign head   = mem_q[rptr_q];

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign cmp_vld = rd_acc;
      assign cmp_dat = head;
    end else begin : g_pipe
      logic [RD_LAT-1:0] vld_q;
      logic [DW-1:0]     dat_q [RD_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= rd_acc;
          dat_q[0] <= head;
          for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end
      assign cmp_vld = vld_q[RD_LAT-1];
      assign cmp_dat = dat_q[RD_LAT-1];
    end
  endgenerate

  assign ev_ovf  = wr_x | (wr_ok & ~wr_acc);
  assign ev_udf  = rd_x | (rd_ok & (level_q == '0));
  assign ev_dat  = cmp_vld & (out != cmp_dat);
  assign ev_full = dut_full != (level_q == LVL_FULL);
  assign ev_emp  = dut_empty != (level_q == '0);
  assign any_ev  = ev_ovf | ev_udf | ev_dat | ev_full | ev_emp;
  assign ev_num  = 3'(ev_ovf) + 3'(ev_udf) + 3'(ev_dat) + 3'(ev_full) + 3'(ev_emp);
  assign ev_inc  = (ev_num > 3'd3) ? 2'd3 : ev_num[1:0];

  always_comb begin
    ev_code = 3'd0;
    if      (ev_ovf)  ev_code = 3'd1;
    else if (ev_udf)  ev_code = 3'd2;
    else if (ev_dat)  ev_code = 3'd3;
    else if (ev_full) ev_code = 3'd4;
    else if (ev_emp)  ev_code = 3'd5;
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    err_d       = err_q | any_ev;
    code_d      = code_q;
    exp_d       = exp_q;
    obs_d       = obs_q;
    err_cnt_d   = sat_add(err_cnt_q, ev_inc);
    wr_cnt_d    = sat_add(wr_cnt_q, {1'b0, wr_acc});
    rd_cnt_d    = sat_add(rd_cnt_q, {1'b0, cmp_vld});
    cov_full_d  = sat_add(cov_full_q, {1'b0, level_q == LVL_FULL});
    cov_simul_d = sat_add(cov_simul_q, {1'b0, wr_acc & rd_acc});
    if (wr_acc) wptr_d = wptr_q + AW'(1);
    if (rd_acc) rptr_d = rptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Only the first error is captured; data words are kept only for a mismatch.
    if (!err_q && any_ev) begin
      code_d = ev_code;
      if (ev_code == 3'd3) begin
        exp_d = cmp_dat;
        obs_d = out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      err_q       <= 1'b0;
      code_q      <= '0;
      exp_q       <= '0;
      obs_q       <= '0;
      err_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      cov_full_q  <= '0;
      cov_simul_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      err_q       <= err_d;
      code_q      <= code_d;
      exp_q       <= exp_d;
      obs_q       <= obs_d;
      err_cnt_q   <= err_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      cov_full_q  <= cov_full_d;
      cov_simul_q <= cov_simul_d;
    end
  end

  assign err       = err_q;
  assign err_code  = code_q;
  assign exp_data  = exp_q;
  assign obs_data  = obs_q;
  assign err_cnt   = err_cnt_q;
  assign level     = level_q;
  assign wr_cnt    = wr_cnt_q;
  assign rd_cnt    = rd_cnt_q;
  assign cov_full  = cov_full_q;
  assign cov_simul = cov_simul_q;

endmodule

// File: tb/tb_wr_rd_scoreboard_mon.sv
// Directed bench for wr_rd_scoreboard_mon: main instance at RD_LAT=1 plus
// RD_LAT=0 and RD_LAT=3 instances sharing the strobes for the latency scenario.
module tb_wr_rd_scoreboard_mon;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, wr, rd, dut_full, dut_empty;
  logic [7:0] din, dout, dout0, dout3;
  logic       bad_empty;
  int         exp_lvl;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic        m_err, a0_err, a3_err;
  logic [2:0]  m_code, a0_code, a3_code;
  logic [7:0]  m_exp, m_obs, a0_exp, a0_obs, a3_exp, a3_obs;
  logic [15:0] m_ecnt, m_wcnt, m_rcnt, m_cfull, m_csim;
  logic [15:0] a0_ecnt, a0_wcnt, a0_rcnt, a0_cfull, a0_csim;
  logic [15:0] a3_ecnt, a3_wcnt, a3_rcnt, a3_cfull, a3_csim;
  logic [4:0]  m_lvl, a0_lvl, a3_lvl;

  wr_rd_scoreboard_mon #(.DW(8), .DEPTH(16), .RD_LAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .in(din), .out(dout),
    .dut_full(dut_full), .dut_empty(dut_empty), .err(m_err), .err_code(m_code),
    .exp_data(m_exp), .obs_data(m_obs), .err_cnt(m_ecnt), .level(m_lvl),
    .wr_cnt(m_wcnt), .rd_cnt(m_rcnt), .cov_full(m_cfull), .cov_simul(m_csim));

  wr_rd_scoreboard_mon #(.DW(8), .DEPTH(16), .RD_LAT(0), .CNT_W(16)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .in(din), .out(dout0),
    .dut_full(dut_full), .dut_empty(dut_empty), .err(a0_err), .err_code(a0_code),
    .exp_data(a0_exp), .obs_data(a0_obs), .err_cnt(a0_ecnt), .level(a0_lvl),
    .wr_cnt(a0_wcnt), .rd_cnt(a0_rcnt), .cov_full(a0_cfull), .cov_simul(a0_csim));

  wr_rd_scoreboard_mon #(.DW(8), .DEPTH(16), .RD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .in(din), .out(dout3),
    .dut_full(dut_full), .dut_empty(dut_empty), .err(a3_err), .err_code(a3_code),
    .exp_data(a3_exp), .obs_data(a3_obs), .err_cnt(a3_ecnt), .level(a3_lvl),
    .wr_cnt(a3_wcnt), .rd_cnt(a3_rcnt), .cov_full(a3_cfull), .cov_simul(a3_csim));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus; flags follow the bench's own occupancy count.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d_in, input logic [7:0] d_out);
    logic ra, wa;
    wr = w; rd = r; din = d_in; dout = d_out;
    dut_full  = (exp_lvl == 16);
    dut_empty = (exp_lvl == 0) ^ bad_empty;
    @(posedge clk); #1;
    ra = r && (exp_lvl > 0);
    wa = w && ((exp_lvl < 16) || ra);
    exp_lvl = exp_lvl + int'(wa) - int'(ra);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; din = '0; dout = '0; dout0 = '0; dout3 = '0;
    bad_empty = 1'b0; exp_lvl = 0; dut_full = 1'b0; dut_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rv(input int k);
    return (k < 4) ? 8'(8'hA0 + k) : 8'(8'hB0 + k - 4);
  endfunction

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; din = '0; dout = '0; dout0 = '0; dout3 = '0;
    bad_empty = 1'b0; exp_lvl = 0; dut_full = 1'b0; dut_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_err", 32'(m_err), 0);
    check_eq("rst_code", 32'(m_code), 0);
    check_eq("rst_level", 32'(m_lvl), 0);
    check_eq("rst_errcnt", 32'(m_ecnt), 0);
    check_eq("rst_wrcnt", 32'(m_wcnt), 0);
    rst_n = 1'b1;

    // Latency variants: level 4, then 8 simultaneous wr/rd cycles.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i), 8'h00);
    for (int t = 0; t < 11; t++) begin
      dout0 = (t < 8) ? rv(t) : 8'h00;
      dout3 = (t >= 3) ? rv(t - 3) : 8'h00;
      cyc(t < 8, t < 8, 8'(8'hB0 + t), (t >= 1 && t < 9) ? rv(t - 1) : 8'h00);
    end
    check_eq("l1_simul", 32'(m_csim), 8);
    check_eq("l1_level", 32'(m_lvl), 4);
    check_eq("l1_err", 32'(m_err), 0);
    check_eq("l1_rdcnt", 32'(m_rcnt), 8);
    check_eq("l1_wrcnt", 32'(m_wcnt), 12);
    check_eq("l0_simul", 32'(a0_csim), 8);
    check_eq("l0_level", 32'(a0_lvl), 4);
    check_eq("l0_err", 32'(a0_err), 0);
    check_eq("l0_rdcnt", 32'(a0_rcnt), 8);
    check_eq("l3_simul", 32'(a3_csim), 8);
    check_eq("l3_level", 32'(a3_lvl), 4);
    check_eq("l3_err", 32'(a3_err), 0);
    check_eq("l3_rdcnt", 32'(a3_rcnt), 8);

    // Fill 0x01..0x10, drain with matching data.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i + 1), 8'h00);
    check_eq("fill_level", 32'(m_lvl), 16);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00, 8'(i));
    cyc(1'b0, 1'b0, 8'h00, 8'h10);
    check_eq("drain_err", 32'(m_err), 0);
    check_eq("drain_wrcnt", 32'(m_wcnt), 16);
    check_eq("drain_rdcnt", 32'(m_rcnt), 16);
    check_eq("drain_level", 32'(m_lvl), 0);
    check_eq("drain_covfull", 32'(m_cfull), 1);

    // Overflow at full: 0xAA dropped, later reads still match.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i), 8'h00);
    cyc(1'b1, 1'b0, 8'hAA, 8'h00);
    check_eq("ovf_code", 32'(m_code), 1);
    check_eq("ovf_err", 32'(m_err), 1);
    check_eq("ovf_level", 32'(m_lvl), 16);
    check_eq("ovf_errcnt", 32'(m_ecnt), 1);
    check_eq("ovf_wrcnt", 32'(m_wcnt), 32);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00, (i == 0) ? 8'h00 : 8'(8'h20 + i - 1));
    cyc(1'b0, 1'b0, 8'h00, 8'h2F);
    check_eq("ovf_rd_errcnt", 32'(m_ecnt), 1);
    check_eq("ovf_rd_rdcnt", 32'(m_rcnt), 32);
    check_eq("ovf_rd_level", 32'(m_lvl), 0);

    // Write and read together at empty: stored, read is an underflow.
    do_reset();
    cyc(1'b1, 1'b1, 8'h55, 8'h00);
    check_eq("udf_code", 32'(m_code), 2);
    check_eq("udf_level", 32'(m_lvl), 1);
    check_eq("udf_errcnt", 32'(m_ecnt), 1);
    cyc(1'b0, 1'b1, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 8'h55);
    check_eq("udf_rd_errcnt", 32'(m_ecnt), 1);
    check_eq("udf_rd_rdcnt", 32'(m_rcnt), 1);
    check_eq("udf_rd_level", 32'(m_lvl), 0);

    // Data mismatch, then a flag error with the capture frozen.
    do_reset();
    cyc(1'b1, 1'b0, 8'h3C, 8'h00);
    cyc(1'b0, 1'b1, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 8'h3D);
    check_eq("dat_code", 32'(m_code), 3);
    check_eq("dat_exp", 32'(m_exp), 32'h3C);
    check_eq("dat_obs", 32'(m_obs), 32'h3D);
    check_eq("dat_errcnt", 32'(m_ecnt), 1);
    bad_empty = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    bad_empty = 1'b0;
    check_eq("frz_errcnt", 32'(m_ecnt), 2);
    check_eq("frz_code", 32'(m_code), 3);
    check_eq("frz_exp", 32'(m_exp), 32'h3C);
    check_eq("frz_obs", 32'(m_obs), 32'h3D);

    // Empty-flag mismatch for 3 cycles, then async reset with a compare pending.
    do_reset();
    bad_empty = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    bad_empty = 1'b0;
    check_eq("emp_code", 32'(m_code), 5);
    check_eq("emp_errcnt", 32'(m_ecnt), 3);
    check_eq("emp_expdata", 32'(m_exp), 0);
    cyc(1'b1, 1'b0, 8'h11, 8'h00);
    cyc(1'b0, 1'b1, 8'h00, 8'h00);
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0;
    #1;
    check_eq("arst_err", 32'(m_err), 0);
    check_eq("arst_code", 32'(m_code), 0);
    check_eq("arst_errcnt", 32'(m_ecnt), 0);
    check_eq("arst_level", 32'(m_lvl), 0);
    check_eq("arst_wrcnt", 32'(m_wcnt), 0);
    check_eq("arst_covfull", 32'(m_cfull), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; exp_lvl = 0;
    cyc(1'b0, 1'b0, 8'h00, 8'hFF);
    check_eq("post_err", 32'(m_err), 0);
    check_eq("post_rdcnt", 32'(m_rcnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
